// File: rtl/md5_round_ctrl.sv
// md5_round_ctrl: runs one 512-bit MD5 compression as 64 single-cycle rounds.
// Owns the A/B/C/D working registers, the chaining state, the round counter
// and the per-round schedule (fcalc select, message index, shift, K constant).
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     block handshake from the padding/block feeder
//   in_first              1 = first block of a message (chaining reloads from IV)
//   in_block[511:0]       message block, word M[j] = in_block[32j+31:32j]
//   out_valid/out_ready   digest handshake to the consumer
//   digest[127:0]         {D,C,B,A} chaining state, A in [31:0]
//   busy                  high while rounds or the final add are in progress
//   round_idx[5:0]        current round index (debug)

module md5_fcalc (
  input  logic [1:0]  sel,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] f
);
  always_comb begin
    f = '0;
    unique case (sel)
      2'd0: f = (b & c) | (~b & d);
      2'd1: f = (b & d) | (c & ~d);
      2'd2: f = b ^ c ^ d;
      2'd3: f = c ^ (b | ~d);
    endcase
  end
endmodule

module md5_round_ctrl #(
  parameter logic [31:0] IV_A = 32'h67452301,
  parameter logic [31:0] IV_B = 32'hefcdab89,
  parameter logic [31:0] IV_C = 32'h98badcfe,
  parameter logic [31:0] IV_D = 32'h10325476
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [511:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] digest,
  output logic         busy,
  output logic [5:0]   round_idx
);

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL, ST_DONE} state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  state_t         state_q, state_d;
  logic [5:0]     i_q, i_d;
  logic [31:0]    a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [31:0]    ch_a_q, ch_a_d, ch_b_q, ch_b_d;
  logic [31:0]    ch_c_q, ch_c_d, ch_d_q, ch_d_d;
  logic [511:0]   blk_q, blk_d;
  logic [127:0]   digest_q, digest_d;

  // Round schedule
  logic [1:0]     sel;
  logic [3:0]     i4;
  logic [3:0]     g;
  logic [4:0]     s;
  logic [31:0]    f;
  logic [31:0]    m_word;
  logic [31:0]    t_sum;
  logic [63:0]    rot_full;
  logic [31:0]    rot;

  md5_fcalc u_fcalc (
    .sel (sel),
    .b   (b_q),
    .c   (c_q),
    .d   (d_q),
    .f   (f)
  );

  always_comb begin
    sel = i_q[5:4];
    i4  = i_q[3:0];
    g   = '0;
    unique case (sel)
      2'd0: g = i4;
      2'd1: g = i4 * 4'd5 + 4'd1;
      2'd2: g = i4 * 4'd3 + 4'd5;
      2'd3: g = i4 * 4'd7;
    endcase

    s = '0;
    unique case ({sel, i_q[1:0]})
      4'b00_00: s = 5'd7;   4'b00_01: s = 5'd12;
      4'b00_10: s = 5'd17;  4'b00_11: s = 5'd22;
      4'b01_00: s = 5'd5;   4'b01_01: s = 5'd9;
      4'b01_10: s = 5'd14;  4'b01_11: s = 5'd20;
      4'b10_00: s = 5'd4;   4'b10_01: s = 5'd11;
      4'b10_10: s = 5'd16;  4'b10_11: s = 5'd23;
      4'b11_00: s = 5'd6;   4'b11_01: s = 5'd10;
      4'b11_10: s = 5'd15;  4'b11_11: s = 5'd21;
    endcase

    m_word   = blk_q[{g, 5'd0} +: 32];
    t_sum    = f + a_q + K_ROM[i_q] + m_word;
    // Upper half of the doubled word shifted left is the left rotation.
    rot_full = {t_sum, t_sum} << s;
    rot      = rot_full[63:32];
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      ch_a_q   <= IV_A;
      ch_b_q   <= IV_B;
      ch_c_q   <= IV_C;
      ch_d_q   <= IV_D;
      blk_q    <= '0;
      digest_q <= {IV_D, IV_C, IV_B, IV_A};
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      ch_a_q   <= ch_a_d;
      ch_b_q   <= ch_b_d;
      ch_c_q   <= ch_c_d;
      ch_d_q   <= ch_d_d;
      blk_q    <= blk_d;
      digest_q <= digest_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (in_valid)      state_d = ST_ROUND;
      ST_ROUND: if (i_q == 6'd63)  state_d = ST_FINAL;
      ST_FINAL:                    state_d = ST_DONE;
      ST_DONE:  if (out_ready)     state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    i_d      = i_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    ch_a_d   = ch_a_q;
    ch_b_d   = ch_b_q;
    ch_c_d   = ch_c_q;
    ch_d_d   = ch_d_q;
    blk_d    = blk_q;
    digest_d = digest_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          blk_d = in_block;
          i_d   = '0;
          if (in_first) begin
            a_d    = IV_A;
            b_d    = IV_B;
            c_d    = IV_C;
            d_d    = IV_D;
            ch_a_d = IV_A;
            ch_b_d = IV_B;
            ch_c_d = IV_C;
            ch_d_d = IV_D;
          end else begin
            a_d = ch_a_q;
            b_d = ch_b_q;
            c_d = ch_c_q;
            d_d = ch_d_q;
          end
        end
      end
      ST_ROUND: begin
        a_d = d_q;
        d_d = c_q;
        c_d = b_q;
        b_d = b_q + rot;
        i_d = i_q + 6'd1;
      end
      ST_FINAL: begin
        ch_a_d   = ch_a_q + a_q;
        ch_b_d   = ch_b_q + b_q;
        ch_c_d   = ch_c_q + c_q;
        ch_d_d   = ch_d_q + d_q;
        digest_d = {ch_d_q + d_q, ch_c_q + c_q, ch_b_q + b_q, ch_a_q + a_q};
      end
      ST_DONE: ;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q == ST_ROUND) || (state_q == ST_FINAL);
    round_idx = i_q;
    digest    = digest_q;
  end

endmodule

// File: tb/tb_md5_round_ctrl.sv
module tb_md5_round_ctrl;

  localparam logic [127:0] IV_ST  = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
  localparam logic [127:0] EMPTY  = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
  localparam logic [127:0] ABC    = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};
  localparam int unsigned  SHT [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic [511:0] in_block;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] digest;
  logic         busy;
  logic [5:0]   round_idx;

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] sb_q [$];
  logic [511:0] blk_empty, blk_abc;

  md5_round_ctrl #(
    .IV_A (32'h67452301),
    .IV_B (32'hefcdab89),
    .IV_C (32'h98badcfe),
    .IV_D (32'h10325476)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_block  (in_block),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digest    (digest),
    .busy      (busy),
    .round_idx (round_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference MD5 compression written from the textbook algorithm.
  function automatic logic [127:0] md5_ref(input logic [127:0] st, input logic [511:0] blk);
    logic [31:0] a, b, c, d, f, k, t, tmp;
    int unsigned g, s;
    real r;
    a = st[31:0]; b = st[63:32]; c = st[95:64]; d = st[127:96];
    for (int unsigned i = 0; i < 64; i++) begin
      case (i / 16)
        0: begin f = (b & c) | (~b & d);  g = i;                end
        1: begin f = (d & b) | (~d & c);  g = (5 * i + 1) % 16; end
        2: begin f = b ^ c ^ d;           g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d);  g = (7 * i) % 16;     end
      endcase
      s = SHT[(i / 16) * 4 + (i % 4)];
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      k = 32'(longint'($floor(r * 4294967296.0)));
      t = a + f + k + blk[g * 32 +: 32];
      tmp = d;
      d = c;
      c = b;
      b = b + ((t << s) | (t >> (32 - s)));
      a = tmp;
    end
    return {d + st[127:96], c + st[95:64], b + st[63:32], a + st[31:0]};
  endfunction

  // Scoreboard monitor: pops an expected digest on every output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_digest", 128'd1, 128'd0);
        end else begin
          check("digest", digest, sb_q.pop_front());
        end
      end
    end
  end

  task automatic send_block(input logic [511:0] blk, input logic first, input logic [127:0] exp);
    int unsigned n;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_first = first;
    in_block = blk;
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'($urandom);
    in_block = {16{$urandom}};
  endtask

  task automatic wait_digest();
    int unsigned n, busy_cnt, bad_idx;
    n = 0; busy_cnt = 0; bad_idx = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      if (busy) busy_cnt++;
      if (round_idx != 6'((n < 64) ? n : 0)) bad_idx++;
      n++;
      if (n > 200) break;
    end
    check("latency", 128'(n), 128'd65);
    check("busy_cycles", 128'(busy_cnt), 128'd65);
    check("round_idx_seq", 128'(bad_idx), 128'd0);
    check("busy_in_done", 128'(busy), 128'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  128'(in_ready),  128'd1);
    check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_busy"},      128'(busy),      128'd0);
    check({tag, "_round_idx"}, 128'(round_idx), 128'd0);
    check({tag, "_digest"},    digest,          IV_ST);
  endtask

  initial begin
    logic [127:0] chain2;
    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_block = '0; out_ready = 1'b1;
    blk_empty = '0;
    blk_empty[31:0] = 32'h00000080;
    blk_abc = '0;
    blk_abc[31:0] = 32'h80636261;
    blk_abc[14*32 +: 32] = 32'h00000018;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state("rst");

    // Empty message
    send_block(blk_empty, 1'b1, EMPTY);
    wait_digest();
    @(negedge clk);

    // "abc" with output backpressure
    out_ready = 1'b0;
    send_block(blk_abc, 1'b1, ABC);
    wait_digest();
    in_valid = 1'b1;
    in_block = blk_empty;
    in_first = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("bp_digest",   digest,             ABC);
      check("bp_in_ready", 128'(in_ready),     128'd0);
      check("bp_valid",    128'(out_valid),    128'd1);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("rel_out_valid", 128'(out_valid), 128'd0);
    check("rel_in_ready",  128'(in_ready),  128'd1);
    out_ready = 1'b1;

    // Second "abc" block chained on the first digest
    chain2 = md5_ref(ABC, blk_abc);
    send_block(blk_abc, 1'b0, chain2);
    wait_digest();
    @(negedge clk);

    // Fresh message: no carry-over from the chain
    send_block(blk_empty, 1'b1, EMPTY);
    wait_digest();
    @(negedge clk);

    // Reset during round 30 aborts the block
    send_block(blk_empty, 1'b1, EMPTY);
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_reset_state("midrst");
    send_block(blk_empty, 1'b1, EMPTY);
    wait_digest();

    repeat (3) @(negedge clk);
    check("sb_drained", 128'(sb_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/md5_round_ctrl.md
Name: md5_round_ctrl

Overview:
Sequences one 512-bit MD5 compression through 64 single-cycle rounds around a md5_fcalc instance.
- Owns the A/B/C/D working registers, the chaining state and the round counter.
- Derives the fcalc select, message-word index, shift amount and K constant for each round.
- Sits between the padding/block feeder (upstream) and the digest consumer (downstream), with a valid/ready handshake on both sides.

Parameters:
IV_A, 32'h67452301, initial chaining word A
IV_B, 32'hefcdab89, initial chaining word B
IV_C, 32'h98badcfe, initial chaining word C
IV_D, 32'h10325476, initial chaining word D

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  block available
in_ready  output  1  controller can accept a block
in_first  input  1  sampled with block; 1 = first block of message, reload chaining from IV
in_block  input  512  message block; word M[j] = in_block[32j+31:32j], little-endian words
out_valid  output  1  digest valid
out_ready  input  1  consumer accepts digest
digest  output  128  {D,C,B,A} chaining state; A in [31:0]
busy  output  1  high in ROUND or FINAL
round_idx  output  6  current round i (debug)

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, round_idx=0, chaining=IV, A/B/C/D=0, block register=0, digest=IV.
- States: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_block; i=0.
  - If in_first=1: load A..D and chaining from IV. Otherwise load A..D from chaining.
  - Next state ROUND.
- ROUND (exactly 64 cycles, i=0..63):
  - sel=i[5:4] to md5_fcalc(b=B, c=C, d=D).
  - Message index g, computed mod 16 (4-bit truncation):
    - sel0: g=i
    - sel1: g=5i+1
    - sel2: g=3i+5
    - sel3: g=7i
  - Shift s by sel, indexed by i[1:0]:
    - sel0: {7,12,17,22}
    - sel1: {5,9,14,20}
    - sel2: {4,11,16,23}
    - sel3: {6,10,15,21}
  - K[i] = floor(abs(sin(i+1))*2^32), 64-entry internal constant ROM.
  - T = f + A + K[i] + M[g], all additions mod 2^32.
  - Register update: A<=D; D<=C; C<=B; B<=B+rotl(T,s).
  - i increments each cycle. At i=63 go to FINAL; i wraps to 0.
- FINAL (1 cycle):
  - chaining word X <= chaining X + X (mod 2^32) for each of A..D.
  - digest <= the new chaining value; out_valid<=1; next state DONE.
- DONE:
  - out_valid=1; digest held stable.
  - On out_ready: out_valid<=0, next state IDLE. in_ready rises the cycle after.
  - No block is accepted in DONE, even if out_ready is high.
- Latency: block accepted at edge t0; rounds on edges t1..t64; digest and out_valid registered at t65.
- Chaining persists across blocks until in_first=1 or reset. A multi-block message is fed with in_first=1 on its first block only.
- in_block is used only from the internal latch; upstream may change it after the handshake.
- in_valid outside IDLE is ignored; the block stays pending upstream.
- Reset mid-ROUND or mid-DONE aborts immediately to the reset values above; no partial digest is produced.
- in_valid=0 in IDLE: all state holds.

Test Plan:
- Empty message: in_first=1, block word0=0x00000080, all other words 0 -> exactly 65 cycles later out_valid=1 with A=0xd98c1dd4, B=0x04b2008f, C=0x980980e9, D=0x7e42f8ec.
- "abc": in_first=1, word0=0x80636261, word14=0x00000018, rest 0 -> A=0x98500190, B=0xb04fd23c, C=0x7d3f96d6, D=0x727fe128.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> digest stable, in_ready=0 throughout; then out_ready=1 for 1 cycle -> out_valid=0 next cycle, in_ready=1.
- Chaining: send "abc" block twice, second with in_first=0 -> second digest computed from the first digest as IV. Then send the empty block with in_first=1 -> d98c1dd4... again, with no carry-over.
- Reset at round 30 -> next cycle state IDLE, in_ready=1, out_valid=0, digest=IV. A fresh empty-message block then yields the correct digest.
- Schedule check: monitor round_idx/sel/g -> i=16 gives sel=1, g=1; i=33 gives sel=2, g=8; i=63 gives sel=3, g=9. busy is high for exactly 65 cycles per block.
